// File: rtl/rom_load_arbiter.sv
// ROM loader and runtime patch arbiter: takes the HPS ioctl download stream into a
// single-port BRAM, holds the game in reset while loading, then shares the port with CPU reads.
module rom_load_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ROM_SIZE    = 16'hC000,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  PATCH_INDEX = 8'd1,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              game_reset,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {S_HOLD, S_LOAD, S_FLUSH, S_POST, S_RUN} state_t;

  localparam logic [24:0] ROM_LIMIT = 25'(ROM_SIZE);
  localparam logic [16:0] ROM_BYTES = 17'(ROM_SIZE);
  localparam logic [15:0] POST_LAST = 16'(RST_HOLD - 1);

  state_t              state_q, state_d;
  logic                dl_prev_q, dl_prev_d;
  logic                patch_act_q, patch_act_d;
  logic                buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [7:0]          buf_data_q, buf_data_d;
  logic [3:0]          starve_q, starve_d;
  logic [16:0]         byte_cnt_q, byte_cnt_d;
  logic [15:0]         post_cnt_q, post_cnt_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic                rvalid_q, rvalid_d;

  logic dl_rise, dl_fall, rom_rise, in_run, restart, force_write;
  logic commit, in_range, wr_hit, accept, drop, gnt;

  always_comb begin
    dl_rise     = ioctl_download & ~dl_prev_q;
    dl_fall     = ~ioctl_download & dl_prev_q;
    rom_rise    = dl_rise & (ioctl_index == ROM_INDEX);
    in_run      = (state_q == S_RUN);
    restart     = in_run & rom_rise;
    // A pending patch write must not be lost when a new ROM load takes over the port.
    force_write = in_run & ((buf_vld_q & (starve_q == 4'd8)) | restart);

    commit = 1'b0;
    case (state_q)
      S_LOAD, S_FLUSH: commit = buf_vld_q;
      S_RUN:           commit = buf_vld_q & (~cpu_req | force_write);
      default:         commit = 1'b0;
    endcase

    in_range = (ioctl_addr < ROM_LIMIT);
    wr_hit   = ioctl_wr & in_range & ((state_q == S_LOAD) | (in_run & patch_act_q));
    accept   = wr_hit & (~buf_vld_q | commit);
    drop     = wr_hit & buf_vld_q & ~commit;
    gnt      = cpu_req & in_run & ~force_write;

    state_d     = state_q;
    dl_prev_d   = ioctl_download;
    patch_act_d = ioctl_download & (patch_act_q | (in_run & dl_rise & (ioctl_index == PATCH_INDEX)));
    buf_vld_d   = buf_vld_q & ~commit;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    starve_d    = (buf_vld_q & ~commit) ? starve_q + 4'd1 : 4'd0;
    byte_cnt_d  = byte_cnt_q;
    post_cnt_d  = post_cnt_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q | drop;
    rvalid_d    = gnt;

    if (accept) begin
      buf_vld_d  = 1'b1;
      buf_addr_d = ioctl_addr[ADDR_W-1:0];
      buf_data_d = ioctl_dout;
      starve_d   = 4'd0;
      if (state_q == S_LOAD) byte_cnt_d = byte_cnt_q + 17'd1;
    end

    case (state_q)
      S_HOLD: if (rom_rise) begin
        state_d    = S_LOAD;
        byte_cnt_d = 17'd0;
      end
      S_LOAD: if (dl_fall) state_d = S_FLUSH;
      S_FLUSH: if (!buf_vld_q) begin
        state_d    = S_POST;
        post_cnt_d = 16'd0;
        if (byte_cnt_q < ROM_BYTES) load_err_d = 1'b1;
      end
      S_POST: if (post_cnt_q == POST_LAST) begin
        state_d     = S_RUN;
        load_done_d = 1'b1;
      end else begin
        post_cnt_d = post_cnt_q + 16'd1;
      end
      S_RUN: if (rom_rise) begin
        state_d     = S_LOAD;
        byte_cnt_d  = 17'd0;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        patch_act_d = 1'b0;
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_HOLD;
      dl_prev_q   <= 1'b0;
      patch_act_q <= 1'b0;
      buf_vld_q   <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= 8'd0;
      starve_q    <= 4'd0;
      byte_cnt_q  <= 17'd0;
      post_cnt_q  <= 16'd0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_prev_q   <= dl_prev_d;
      patch_act_q <= patch_act_d;
      buf_vld_q   <= buf_vld_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      starve_q    <= starve_d;
      byte_cnt_q  <= byte_cnt_d;
      post_cnt_q  <= post_cnt_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Outputs are gated by reset so a buffered byte cannot reach the BRAM during an abort.
  // ioctl_wait drops in a cycle where the buffer drains, so back-to-back writes never stall.
  assign ioctl_wait = ~reset & buf_vld_q & ~commit;
  assign cpu_gnt    = ~reset & gnt;
  assign cpu_rvalid = ~reset & rvalid_q;
  assign cpu_rdata  = mem_rdata;
  assign mem_we     = ~reset & commit;
  assign mem_addr   = commit ? buf_addr_q : cpu_addr;
  assign mem_wdata  = buf_data_q;
  assign game_reset = reset | ~in_run | restart;
  assign load_done  = ~reset & load_done_q;
  assign load_err   = ~reset & load_err_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Bench for rom_load_arbiter: vector table for HOLD/LOAD basics, directed corner sequences,
// and randomized RUN arbitration against a queue-based model of the host write path.
module tb_rom_load_arbiter;
  localparam int RST_HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0, ioctl_dout = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic        ioctl_wait;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we;
  logic        game_reset, load_done, load_err;

  rom_load_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .game_reset(game_reset), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk_sys = ~clk_sys;

  // BRAM with 1-cycle read latency, background pattern 0xEE marks untouched bytes.
  logic [7:0] mem [0:65535] = '{default: 8'hEE};
  always @(posedge clk_sys) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  logic mon_load = 1'b0;
  int   wait_in_load = 0, bad_we = 0;
  always @(negedge clk_sys) begin
    if (mon_load && ioctl_wait) wait_in_load <= wait_in_load + 1;
    if (mem_we && mem_addr == 16'hC000) bad_we <= bad_we + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  // Reference memory and host-write model
  logic [7:0] exp_mem [0:65535] = '{default: 8'hEE};
  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t  pend[$];
  int   age = 0;
  logic exp_rv = 1'b0, exp_err = 1'b0;
  logic [7:0] exp_rd = 8'd0;

  task automatic mem_compare(input string nm);
    int bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== exp_mem[a]) bad++;
    check(nm, bad, 0);
  endtask

  task automatic wait_run(input string nm, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk_sys);
      if (!game_reset) break;
      tick();
    end
    check(nm, game_reset, 1'b0);
    tick();
  endtask

  // One RUN cycle with a patch download active: the buffer holds one write, the CPU wins
  // unless the write has waited 8 full cycles, and a write is lost if the buffer stays full.
  task automatic run_step(input logic req, input logic [15:0] ca, input logic wr,
                          input logic [15:0] wa, input logic [7:0] wd);
    logic frc, cmt, egnt, ewait, acc;
    cpu_req = req; cpu_addr = ca; ioctl_wr = wr; ioctl_addr = {9'd0, wa}; ioctl_dout = wd;
    frc   = (pend.size() != 0) && (age == 8);
    cmt   = (pend.size() != 0) && (!req || frc);
    egnt  = req && !frc;
    ewait = (pend.size() != 0) && !cmt;
    acc   = wr && ((pend.size() == 0) || cmt);
    @(negedge clk_sys);
    check("run.gnt", cpu_gnt, egnt);
    check("run.wait", ioctl_wait, ewait);
    check("run.we", mem_we, cmt);
    if (cmt) check("run.waddr", {mem_addr, mem_wdata}, {pend[0].a, pend[0].d});
    check("run.rvalid", cpu_rvalid, exp_rv);
    if (exp_rv) check("run.rdata", cpu_rdata, exp_rd);
    check("run.err", load_err, exp_err);
    exp_rv = egnt;
    if (egnt) exp_rd = exp_mem[ca];
    if (cmt) begin
      exp_mem[pend[0].a] = pend[0].d;
      void'(pend.pop_front());
    end
    if (acc) begin
      pend.push_back('{a: wa, d: wd});
      age = 0;
    end else if (pend.size() != 0) begin
      age++;
    end
    if (wr && !acc) exp_err = 1'b1;
    tick();
  endtask

  typedef struct {
    logic rst, dl; logic [7:0] idx; logic wr; logic [24:0] addr; logic [7:0] dout; logic req;
    logic gr, wt, gnt, we, done, err;
  } vec_t;
  vec_t vt[14];

  initial begin
    int n;
    //        rst dl idx  wr addr        dout  req  gr wt gnt we done err
    vt[0]  = '{1, 0, 8'd0, 0, 25'h0,      8'h00, 0,  1, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 8'd0, 0, 25'h0,      8'h00, 1,  1, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 8'd0, 0, 25'h0,      8'h00, 1,  1, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 1, 8'd1, 0, 25'h0,      8'h00, 1,  1, 0, 0, 0, 0, 0};
    vt[4]  = '{0, 1, 8'd1, 1, 25'h5,      8'h55, 1,  1, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 8'd1, 0, 25'h0,      8'h00, 0,  1, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 1, 8'd0, 0, 25'h0,      8'h00, 0,  1, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 1, 8'd0, 1, 25'h10,     8'h11, 1,  1, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 1, 8'd7, 1, 25'h11,     8'h22, 0,  1, 0, 0, 1, 0, 0};
    vt[9]  = '{0, 1, 8'd0, 1, 25'hC000,   8'h33, 0,  1, 0, 0, 1, 0, 0};
    vt[10] = '{0, 1, 8'd0, 0, 25'h0,      8'h00, 0,  1, 0, 0, 0, 0, 0};
    vt[11] = '{0, 0, 8'd0, 0, 25'h0,      8'h00, 0,  1, 0, 0, 0, 0, 0};
    vt[12] = '{0, 0, 8'd0, 0, 25'h0,      8'h00, 0,  1, 0, 0, 0, 0, 0};
    vt[13] = '{0, 0, 8'd0, 0, 25'h0,      8'h00, 0,  1, 0, 0, 0, 0, 1};

    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rst; ioctl_download = vt[i].dl; ioctl_index = vt[i].idx;
      ioctl_wr = vt[i].wr; ioctl_addr = vt[i].addr; ioctl_dout = vt[i].dout; cpu_req = vt[i].req;
      @(negedge clk_sys);
      check($sformatf("vec%0d.game_reset", i), game_reset, vt[i].gr);
      check($sformatf("vec%0d.wait", i), ioctl_wait, vt[i].wt);
      check($sformatf("vec%0d.gnt", i), cpu_gnt, vt[i].gnt);
      check($sformatf("vec%0d.we", i), mem_we, vt[i].we);
      check($sformatf("vec%0d.done", i), load_done, vt[i].done);
      check($sformatf("vec%0d.err", i), load_err, vt[i].err);
      tick();
    end
    wait_run("tiny.reach_run", 40);
    check("tiny.done", load_done, 1'b1);
    check("tiny.err", load_err, 1'b1);
    exp_mem[16'h10] = 8'h11; exp_mem[16'h11] = 8'h22;
    mem_compare("tiny.mem");

    // Full-size load, back-to-back writes, one out-of-range byte in the middle.
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    ioctl_download = 1'b1; ioctl_index = 8'd0; tick();
    mon_load = 1'b1;
    for (int i = 0; i < 'hC000; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'($urandom);
      exp_mem[i] = ioctl_dout;
      tick();
      if (i == 'h6000) begin
        ioctl_addr = 25'hC000; ioctl_dout = 8'h77; tick();
      end
    end
    mon_load = 1'b0;
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_sys);
      if (!game_reset) break;
      n++;
      tick();
    end
    // fall-detect cycle + one FLUSH cycle (buffer drained) + RST_HOLD cycles of POST
    check("full.reset_cycles", n, 2 + RST_HOLD);
    check("full.done", load_done, 1'b1);
    check("full.err", load_err, 1'b0);
    check("full.wait_during_load", wait_in_load, 0);
    check("full.we_at_C000", bad_we, 0);
    tick();
    mem_compare("full.mem");

    // Starvation: CPU holds the port, patch write 0x1234=A5 forced on the 9th full cycle.
    cpu_req = 1'b1; cpu_addr = 16'h0000;
    ioctl_download = 1'b1; ioctl_index = 8'd1; tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h1234; ioctl_dout = 8'hA5;
    @(negedge clk_sys);
    check("starve.gnt_w", cpu_gnt, 1'b1);
    tick();
    ioctl_wr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_sys);
      check($sformatf("starve%0d.wait", k), ioctl_wait, k < 9);
      check($sformatf("starve%0d.gnt", k), cpu_gnt, k != 9);
      check($sformatf("starve%0d.we", k), mem_we, k == 9);
      if (k == 9) check("starve.waddr", {mem_addr, mem_wdata}, {16'h1234, 8'hA5});
      tick();
    end
    exp_mem[16'h1234] = 8'hA5;
    cpu_addr = 16'h1234;
    @(negedge clk_sys);
    check("readback.gnt", cpu_gnt, 1'b1);
    tick();
    cpu_req = 1'b0;
    @(negedge clk_sys);
    check("readback.rvalid", cpu_rvalid, 1'b1);
    check("readback.rdata", cpu_rdata, 8'hA5);
    tick();

    // Randomized arbitration while the patch download stays open.
    exp_rv = 1'b0; exp_err = 1'b0; age = 0;
    for (int i = 0; i < 2000; i++)
      run_step($urandom_range(0, 9) < 7, 16'h1230 + 16'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 16'h1230 + 16'($urandom_range(0, 15)), 8'($urandom));
    ioctl_download = 1'b0;
    for (int i = 0; i < 3; i++) run_step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0);
    mem_compare("random.mem");

    // ROM download while the CPU reads and a patch byte is still buffered.
    cpu_req = 1'b1; cpu_addr = 16'h0040;
    ioctl_download = 1'b1; ioctl_index = 8'd1; tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'h1300; ioctl_dout = 8'h5A; tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("restart.pre_gnt", cpu_gnt, 1'b1);
    check("restart.pre_done", load_done, 1'b1);
    tick();
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    @(negedge clk_sys);
    check("restart.gnt", cpu_gnt, 1'b0);
    check("restart.game_reset", game_reset, 1'b1);
    check("restart.flush_we", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h1300, 8'h5A});
    tick();
    exp_mem[16'h1300] = 8'h5A;
    @(negedge clk_sys);
    check("restart.done", load_done, 1'b0);
    check("restart.err", load_err, 1'b0);
    check("restart.game_reset2", game_reset, 1'b1);
    tick();

    // Abort after 50 bytes: the 51st is still buffered when reset hits.
    for (int i = 0; i < 50; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h2000 + 25'(i); ioctl_dout = 8'h80 + 8'(i);
      exp_mem[16'h2000 + i] = ioctl_dout;
      tick();
    end
    ioctl_addr = 25'h2032; ioctl_dout = 8'hC3; tick();
    ioctl_wr = 1'b0; reset = 1'b1;
    @(negedge clk_sys);
    check("abort.we", mem_we, 1'b0);
    check("abort.game_reset", game_reset, 1'b1);
    check("abort.flags", {ioctl_wait, cpu_gnt, cpu_rvalid, load_done, load_err}, 5'b0);
    tick(); tick();
    reset = 1'b0; ioctl_download = 1'b0; tick();
    ioctl_download = 1'b1; ioctl_index = 8'd1; tick();
    for (int j = 0; j < 3; j++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h1400 + 25'(j); ioctl_dout = 8'h99;
      @(negedge clk_sys);
      check($sformatf("hold%0d", j), {game_reset, cpu_gnt, mem_we, ioctl_wait}, 4'b1000);
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0; tick();
    mem_compare("abort.mem");

    // Short load of 0x100 bytes with irregular gaps.
    ioctl_download = 1'b1; ioctl_index = 8'd0; tick();
    for (int i = 0; i < 'h100; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'($urandom);
      exp_mem[i] = ioctl_dout;
      tick();
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    ioctl_download = 1'b0;
    wait_run("short.reach_run", 100);
    check("short.done", load_done, 1'b1);
    check("short.err", load_err, 1'b1);
    mem_compare("short.mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
